// File: rtl/pir_alarm_ctrl.sv
// pir_alarm_ctrl: debounced multi-sensor PIR alarm controller.
// Latches fired sensors, times the buzzer, re-arms once all sensors are quiet.
module pir_alarm_ctrl #(
    parameter int NUM_SENSORS     = 3,
    parameter int BUZZ_CYCLES     = 100,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               arm,
    input  logic                               stop_alarm,
    input  logic [NUM_SENSORS-1:0]             pir_sensor,
    output logic [NUM_SENSORS-1:0]             led,
    output logic                               buzzer,
    output logic [$clog2(NUM_SENSORS+1)-1:0]   trigger_count,
    output logic [CNT_W-1:0]                   event_total,
    output logic [3:0]                         fsm_state
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TIM_W = $clog2(BUZZ_CYCLES + 1);
    localparam int TC_W  = $clog2(NUM_SENSORS + 1);

    typedef enum logic [3:0] {
        S_DISARMED = 4'b0001,
        S_ARMED    = 4'b0010,
        S_ALARM    = 4'b0100,
        S_CLEAR    = 4'b1000
    } state_e;

    state_e                   state_q;
    logic [NUM_SENSORS-1:0]   led_q;
    logic                     buzzer_q;
    logic [TIM_W-1:0]         timer_q;
    logic [CNT_W-1:0]         evt_q;
    logic [DB_W-1:0]          cnt_q [NUM_SENSORS];
    logic [DB_W-1:0]          cnt_d [NUM_SENSORS];
    logic [NUM_SENSORS-1:0]   det;
    logic [TC_W-1:0]          tc;

    // Per-sensor run-length counters; any low sample restarts qualification
    always_comb begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
            det[i]   = (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES));
            cnt_d[i] = cnt_q[i];
            if (state_q == S_DISARMED || !pir_sensor[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < DB_W'(DEBOUNCE_CYCLES)) begin
                cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Debounce counter registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (rst) cnt_q[i] <= '0;
            else     cnt_q[i] <= cnt_d[i];
        end
    end

    // Alarm FSM with registered led/buzzer/timer/event counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_DISARMED;
            led_q    <= '0;
            buzzer_q <= 1'b0;
            timer_q  <= '0;
            evt_q    <= '0;
        end else if (!arm) begin
            state_q  <= S_DISARMED;
            led_q    <= '0;
            buzzer_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            unique case (state_q)
                S_DISARMED: state_q <= S_ARMED;
                S_ARMED: begin
                    if (|det) begin
                        state_q  <= S_ALARM;
                        buzzer_q <= 1'b1;
                        led_q    <= det;
                        timer_q  <= '0;
                        if (evt_q != {CNT_W{1'b1}})
                            evt_q <= evt_q + CNT_W'(1);
                    end
                end
                S_ALARM: begin
                    if (stop_alarm ||
                        timer_q == TIM_W'(BUZZ_CYCLES - 1)) begin
                        state_q  <= S_CLEAR;
                        buzzer_q <= 1'b0;
                        led_q    <= '0;
                        timer_q  <= '0;
                    end else begin
                        led_q   <= led_q | det;
                        timer_q <= timer_q + TIM_W'(1);
                    end
                end
                S_CLEAR: begin
                    if (pir_sensor == '0) state_q <= S_ARMED;
                end
                default: state_q <= S_DISARMED;
            endcase
        end
    end

    // Popcount of the latched trigger indicators
    always_comb begin
        tc = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            tc = tc + TC_W'(led_q[i]);
        end
    end

    assign led           = led_q;
    assign buzzer        = buzzer_q;
    assign trigger_count = tc;
    assign event_total   = evt_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_pir_alarm_ctrl.sv
// tb_pir_alarm_ctrl: directed + randomized bench for pir_alarm_ctrl.
// Outputs are compared each cycle against a behavioural model.
module tb_pir_alarm_ctrl;

    localparam int NS  = 3;
    localparam int BC  = 100;
    localparam int DB  = 4;
    localparam int CW  = 2;
    localparam int MAXEVT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, arm, stop_alarm;
    logic [NS-1:0] pir_sensor;
    logic [NS-1:0] led;
    logic          buzzer;
    logic [1:0]    trigger_count;
    logic [CW-1:0] event_total;
    logic [3:0]    fsm_state;

    always #5 clk = ~clk;

    pir_alarm_ctrl #(
        .NUM_SENSORS(NS),
        .BUZZ_CYCLES(BC),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arm(arm),
        .stop_alarm(stop_alarm),
        .pir_sensor(pir_sensor),
        .led(led),
        .buzzer(buzzer),
        .trigger_count(trigger_count),
        .event_total(event_total),
        .fsm_state(fsm_state)
    );

    int checks = 0;
    int failures = 0;

    // Model: 0=disarmed 1=armed 2=alarm 3=clear
    int            m_mode = 0;
    int            run [NS];
    logic [NS-1:0] m_led = '0;
    int            m_evt = 0;
    int            on_cycles = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NS-1:0] q;
        for (int i = 0; i < NS; i++) q[i] = (run[i] >= DB);
        if (rst) begin
            m_mode = 0; m_led = '0; m_evt = 0; on_cycles = 0;
            for (int i = 0; i < NS; i++) run[i] = 0;
            return;
        end
        for (int i = 0; i < NS; i++) begin
            if (m_mode == 0 || !pir_sensor[i]) run[i] = 0;
            else if (run[i] < 1000) run[i] = run[i] + 1;
        end
        if (!arm) begin
            m_mode = 0; m_led = '0; on_cycles = 0;
            return;
        end
        case (m_mode)
            0: m_mode = 1;
            1: if (q != '0) begin
                m_mode = 2; m_led = q; on_cycles = 1;
                m_evt = (m_evt < MAXEVT) ? m_evt + 1 : MAXEVT;
            end
            2: if (stop_alarm || on_cycles == BC) begin
                m_mode = 3; m_led = '0; on_cycles = 0;
            end else begin
                m_led = m_led | q; on_cycles++;
            end
            default: if (pir_sensor == '0) m_mode = 1;
        endcase
    endtask

    task automatic compare();
        chk("state", 32'(fsm_state), 32'(1 << m_mode));
        chk("buzzer", 32'(buzzer), 32'(m_mode == 2));
        chk("led", 32'(led), 32'(m_led));
        chk("tcount", 32'(trigger_count), 32'($countones(m_led)));
        chk("evt", 32'(event_total), 32'(m_evt));
    endtask

    task automatic step(logic r, logic a, logic s, logic [NS-1:0] p);
        rst = r; arm = a; stop_alarm = s; pir_sensor = p;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic trigger(logic [NS-1:0] p);
        int k = 0;
        while (buzzer !== 1'b1 && k < 20) begin
            step(1'b0, 1'b1, 1'b0, p);
            k++;
        end
        chk("trigger_reached", 32'(buzzer), 32'd1);
    endtask

    initial begin
        logic [NS-1:0] rp;
        int hi;
        int saved;
        for (int i = 0; i < NS; i++) run[i] = 0;
        rst = 1'b1; arm = 1'b0; stop_alarm = 1'b0; pir_sensor = '0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 3'b000);
        step(1'b1, 1'b1, 1'b1, 3'b111);
        chk("rst_state", 32'(fsm_state), 32'h1);
        chk("rst_evt", 32'(event_total), 32'd0);
        chk("rst_led", 32'(led), 32'd0);

        // Debounce glitches: 3-cycle pulses never qualify
        step(1'b0, 1'b1, 1'b0, 3'b000);
        for (int r = 0; r < 5; r++) begin
            repeat (3) step(1'b0, 1'b1, 1'b0, 3'b001);
            step(1'b0, 1'b1, 1'b0, 3'b000);
        end
        chk("glitch_buzz", 32'(buzzer), 32'd0);
        chk("glitch_led", 32'(led), 32'd0);
        chk("glitch_evt", 32'(event_total), 32'd0);

        // Alarm and timeout from a fresh ARMED period
        step(1'b1, 1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b1, 1'b0, 3'b010);
        for (int e = 0; e < DB; e++) begin
            step(1'b0, 1'b1, 1'b0, 3'b010);
            chk("pre_alarm_buzz", 32'(buzzer), 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 3'b010);
        chk("alarm_buzz", 32'(buzzer), 32'd1);
        chk("alarm_led", 32'(led), 32'b010);
        chk("alarm_tc", 32'(trigger_count), 32'd1);
        chk("alarm_evt", 32'(event_total), 32'd1);
        hi = 1;
        for (int k = 0; k < 200; k++) begin
            step(1'b0, 1'b1, 1'b0, 3'b010);
            if (buzzer !== 1'b1) break;
            hi++;
        end
        chk("buzz_len", 32'(hi), 32'd100);
        chk("timeout_state", 32'(fsm_state), 32'h8);

        // Re-arm lockout while sensor 1 stays high
        repeat (20) step(1'b0, 1'b1, 1'b0, 3'b010);
        chk("lockout_state", 32'(fsm_state), 32'h8);
        chk("lockout_evt", 32'(event_total), 32'd1);
        step(1'b0, 1'b1, 1'b0, 3'b000);
        chk("rearm_state", 32'(fsm_state), 32'h2);
        for (int e = 0; e < DB; e++) step(1'b0, 1'b1, 1'b0, 3'b001);
        chk("rearm_wait", 32'(buzzer), 32'd0);
        step(1'b0, 1'b1, 1'b0, 3'b001);
        chk("second_alarm", 32'(buzzer), 32'd1);
        chk("second_evt", 32'(event_total), 32'd2);

        // Multi-sensor latch, then operator stop
        repeat (10) step(1'b0, 1'b1, 1'b0, 3'b001);
        repeat (DB + 1) step(1'b0, 1'b1, 1'b0, 3'b101);
        chk("multi_led", 32'(led), 32'b101);
        chk("multi_tc", 32'(trigger_count), 32'd2);
        step(1'b0, 1'b1, 1'b1, 3'b101);
        chk("stop_buzz", 32'(buzzer), 32'd0);
        chk("stop_led", 32'(led), 32'd0);
        chk("stop_state", 32'(fsm_state), 32'h8);
        step(1'b0, 1'b1, 1'b0, 3'b000);

        // Disarm mid-alarm keeps the event count
        trigger(3'b100);
        repeat (3) step(1'b0, 1'b1, 1'b0, 3'b100);
        saved = int'(event_total);
        step(1'b0, 1'b0, 1'b0, 3'b100);
        chk("disarm_state", 32'(fsm_state), 32'h1);
        chk("disarm_buzz", 32'(buzzer), 32'd0);
        chk("disarm_led", 32'(led), 32'd0);
        chk("disarm_evt", 32'(event_total), 32'd3);
        chk("disarm_evt_kept", 32'(event_total), 32'(saved));

        // Reset mid-alarm
        step(1'b0, 1'b1, 1'b0, 3'b000);
        trigger(3'b011);
        step(1'b1, 1'b1, 1'b1, 3'b111);
        chk("rstmid_state", 32'(fsm_state), 32'h1);
        chk("rstmid_buzz", 32'(buzzer), 32'd0);
        chk("rstmid_led", 32'(led), 32'd0);
        chk("rstmid_tc", 32'(trigger_count), 32'd0);
        chk("rstmid_evt", 32'(event_total), 32'd0);

        // Counter saturation after five alarms
        step(1'b0, 1'b1, 1'b0, 3'b000);
        for (int n = 0; n < 5; n++) begin
            trigger(3'b001);
            step(1'b0, 1'b1, 1'b1, 3'b000);
            step(1'b0, 1'b1, 1'b0, 3'b000);
        end
        chk("sat_evt", 32'(event_total), 32'd3);

        // Randomized phase against the model
        rp = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NS; i++)
                if ($urandom_range(0, 5) == 0) rp[i] = ~rp[i];
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 24) == 0),
                 rp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
